// File: rtl/i2s_audio_tx.sv
// Philips I2S transmitter for the 9-bit excess-256 L/R mix words; generates BCLK/LRCK from Clk.
// Optional build macro I2S_TX_DITHER_EN: fill the LSB padding of each slot from a 16-bit LFSR.
module i2s_audio_tx #(
    parameter int CLK_DIV   = 4,
    parameter int WORD_BITS = 16
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [8:0] left_in,
    input  logic [8:0] right_in,
    output logic       i2s_bclk,
    output logic       i2s_lrck,
    output logic       i2s_sdata,
    output logic       sample_strobe
);
    localparam int FRAME = 2 * WORD_BITS;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int N_W   = $clog2(FRAME);
    localparam int PAD   = WORD_BITS - 9;
    localparam logic [WORD_BITS-1:0] PAD_MASK = (WORD_BITS'(1) << PAD) - WORD_BITS'(1);

    logic [DIV_W-1:0]     div_q, div_d;
    logic [N_W-1:0]       n_q, n_d;
    logic [FRAME-1:0]     shreg_q, shreg_d;
    logic                 bclk_q, bclk_d;
    logic                 lrck_q, lrck_d;
    logic                 sdata_q, sdata_d;
    logic                 strobe_q, strobe_d;
    logic [WORD_BITS-1:0] pad_w, left_w, right_w;
    logic                 tc, fall, load;

    // Offset-binary to two's complement (flip MSB), left-justified in the slot.
    function automatic logic [WORD_BITS-1:0] conv(input logic [8:0] x,
                                                  input logic [WORD_BITS-1:0] pad);
        return (WORD_BITS'({~x[8], x[7:0]}) << PAD) | (pad & PAD_MASK);
    endfunction

`ifdef I2S_TX_DITHER_EN
    logic [15:0] lfsr_q, lfsr_d;

    assign pad_w = WORD_BITS'(lfsr_q);

    // Fibonacci LFSR, taps 16,14,13,11; steps once per captured sample pair.
    always_comb begin
        lfsr_d = lfsr_q;
        if (load)
            lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end

    always_ff @(posedge Clk) begin
        if (Reset) lfsr_q <= 16'hACE1;
        else       lfsr_q <= lfsr_d;
    end
`else
    assign pad_w = '0;
`endif

    assign tc      = (div_q == DIV_W'(CLK_DIV - 1));
    assign fall    = tc && bclk_q;
    assign n_d     = !fall                       ? n_q :
                     (n_q == N_W'(FRAME - 1))    ? '0  : n_q + N_W'(1);
    assign load    = fall && (n_d == N_W'(1));
    assign left_w  = conv(left_in,  pad_w);
    assign right_w = conv(right_in, pad_w);

    // Everything but BCLK moves on the falling edge so the codec sees stable data at rise.
    always_comb begin
        div_d    = tc ? '0 : div_q + DIV_W'(1);
        bclk_d   = tc ? ~bclk_q : bclk_q;
        lrck_d   = lrck_q;
        sdata_d  = sdata_q;
        shreg_d  = shreg_q;
        strobe_d = load;
        if (load) begin
            shreg_d = {left_w, right_w};
            sdata_d = left_w[WORD_BITS-1];
        end else if (fall) begin
            shreg_d = shreg_q << 1;
            sdata_d = shreg_q[FRAME-2];
        end
        if (fall)
            lrck_d = (n_d >= N_W'(WORD_BITS));
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            div_q    <= '0;
            n_q      <= '0;
            shreg_q  <= '0;
            bclk_q   <= 1'b0;
            lrck_q   <= 1'b0;
            sdata_q  <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            div_q    <= div_d;
            n_q      <= n_d;
            shreg_q  <= shreg_d;
            bclk_q   <= bclk_d;
            lrck_q   <= lrck_d;
            sdata_q  <= sdata_d;
            strobe_q <= strobe_d;
        end
    end

    assign i2s_bclk      = bclk_q;
    assign i2s_lrck      = lrck_q;
    assign i2s_sdata     = sdata_q;
    assign sample_strobe = strobe_q;

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Scoreboard bench for i2s_audio_tx: timing/frame model from cycle arithmetic, monitor deserialises I2S.
module tb_i2s_audio_tx;
    localparam int CD       = 4;
    localparam int W        = 16;
    localparam int FR       = 2 * W;
    localparam int LOAD_PER = 4 * CD * W;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [8:0] left_in = 9'h100;
    logic [8:0] right_in = 9'h100;
    logic       i2s_bclk, i2s_lrck, i2s_sdata, sample_strobe;

    i2s_audio_tx #(.CLK_DIV(CD), .WORD_BITS(W)) dut (
        .Clk(Clk), .Reset(Reset), .left_in(left_in), .right_in(right_in),
        .i2s_bclk(i2s_bclk), .i2s_lrck(i2s_lrck), .i2s_sdata(i2s_sdata),
        .sample_strobe(sample_strobe)
    );

    always #5 Clk = ~Clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Slot word from the spec's arithmetic: signed value (x-256) scaled to the top of the slot.
    function automatic logic [W-1:0] ref_word(input logic [8:0] x, input logic [W-1:0] pad);
        longint v;
        v = (longint'(x) - 256) * (longint'(1) << (W - 9));
        v = v + longint'(pad);
        return v[W-1:0];
    endfunction

    // ---------------- reference model (runs on Clk count since reset release) ----------------
    int            t = 0;
    int            m_tn, m_n;
    logic          m_ld;
    logic [W-1:0]  m_pad;
    logic          ex_bclk = 1'b0, ex_lrck = 1'b0, ex_strb = 1'b0;
    logic [FR-1:0] sb_q[$];
`ifdef I2S_TX_DITHER_EN
    logic [15:0]   m_lfsr = 16'hACE1;
`endif

    always @(posedge Clk) begin
        m_tn = Reset ? 0 : t + 1;
        m_n  = (m_tn / (2 * CD)) % FR;
        m_ld = !Reset && (m_tn % (2 * CD) == 0) && (m_n == 1);
        t       <= m_tn;
        ex_bclk <= ((m_tn / CD) % 2) == 1;
        ex_lrck <= m_n >= W;
        ex_strb <= m_ld;
`ifdef I2S_TX_DITHER_EN
        m_pad = W'(m_lfsr) & W'((1 << (W - 9)) - 1);
        if (Reset) m_lfsr <= 16'hACE1;
        else if (m_ld) m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
`else
        m_pad = '0;
`endif
        if (Reset) sb_q.delete();
        else if (m_ld) sb_q.push_back({ref_word(left_in, m_pad), ref_word(right_in, m_pad)});
    end

    // ---------------- monitor ----------------
    logic          prev_bclk = 1'b0;
    logic          in_fr = 1'b0;
    int            nb = 0;
    int            frames = 0;
    logic [FR-1:0] dbits = '0, lbits = '0, fd, fl, ef, exp_lr;

    initial for (int i = 0; i < FR; i++) exp_lr[FR-1-i] = (((i + 1) % FR) >= W);

    always @(negedge Clk) begin
        chk("bclk", i2s_bclk, ex_bclk);
        chk("lrck", i2s_lrck, ex_lrck);
        chk("strobe", sample_strobe, ex_strb);
        prev_bclk <= i2s_bclk;
        if (Reset) begin
            in_fr <= 1'b0;
            nb    <= 0;
        end else begin
            if (i2s_bclk && !prev_bclk && in_fr) begin
                fd = {dbits[FR-2:0], i2s_sdata};
                fl = {lbits[FR-2:0], i2s_lrck};
                if (nb == FR - 1) begin
                    if (sb_q.size() == 0) chk("frame_queue_nonempty", sb_q.size(), 1);
                    else begin
                        ef = sb_q.pop_front();
                        chk("left_word", fd[FR-1:W], ef[FR-1:W]);
                        chk("right_word", fd[W-1:0], ef[W-1:0]);
                        chk("lrck_pattern", fl, exp_lr);
                        frames++;
                    end
                    in_fr <= 1'b0;
                    nb    <= 0;
                end else begin
                    dbits <= fd;
                    lbits <= fl;
                    nb    <= nb + 1;
                end
            end
            if (sample_strobe) begin
                if (in_fr) chk("bits_before_next_strobe", nb, FR - 1);
                in_fr <= 1'b1;
                nb    <= 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_strobe(output int k);
        k = 0;
        do begin
            @(posedge Clk); #1;
            k++;
        end while (!sample_strobe && k < 4 * LOAD_PER);
        chk("strobe_seen", sample_strobe, 1'b1);
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_bclk"}, i2s_bclk, 1'b0);
        chk({pfx, "_lrck"}, i2s_lrck, 1'b0);
        chk({pfx, "_sdata"}, i2s_sdata, 1'b0);
        chk({pfx, "_strobe"}, sample_strobe, 1'b0);
    endtask

    initial begin
        int k;
        Reset = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        chk_zero("reset");
        Reset    = 1'b0;
        left_in  = 9'h1FF;
        right_in = 9'h000;
        wait_strobe(k);
        chk("first_strobe_cycle", k, 2 * CD);
        wait_strobe(k);
        chk("strobe_period", k, LOAD_PER);

        left_in  = 9'h100;
        right_in = 9'h100;
        wait_strobe(k);
        wait_strobe(k);

        // Input change mid-frame must only reach the next frame.
        left_in  = 9'h180;
        right_in = 9'(($urandom) % 512);
        wait_strobe(k);
        repeat (4 * 2 * CD) @(posedge Clk);
        #1;
        left_in = 9'h080;
        wait_strobe(k);

        for (int c = 0; c < 4 * LOAD_PER; c++) begin
            @(posedge Clk); #1;
            if ($urandom_range(0, 15) == 0) begin
                left_in  = 9'(($urandom) % 512);
                right_in = 9'(($urandom) % 512);
            end
        end

        // Reset in the right slot (n=20) for a single Clk.
        wait_strobe(k);
        repeat (19 * 2 * CD) @(posedge Clk);
        #1;
        Reset = 1'b1;
        @(posedge Clk); #1;
        chk_zero("midframe_reset");
        Reset = 1'b0;
        wait_strobe(k);
        chk("strobe_after_reset", k, 2 * CD);
        left_in  = 9'(($urandom) % 512);
        right_in = 9'(($urandom) % 512);
        wait_strobe(k);
        wait_strobe(k);

        chk("frames_checked_enough", frames >= 8, 1'b1);
        chk("queue_depth_end", sb_q.size(), 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
